bin2ascii_seq: RTL and testbench

//  Sequential binary-to-ASCII decimal formatter for the seven-segment/character display path.

---
 rtl/num_fmt_pkg.sv | 22 ++
 rtl/bcd_add3_step.sv | 17 +
 rtl/bin2ascii_seq.sv | 131 +++++++++++++
 tb/tb_bin2ascii_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/num_fmt_pkg.sv
// Shared definitions for the number-formatting blocks.
//   ASCII_*    : character codes used when building display strings
//   fmt_state_e: conversion FSM states
//   bcd_digits : number of BCD digits needed to hold 2**w-1
package num_fmt_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2,
        HOLD   = 2'd3
    } fmt_state_e;

    function automatic int bcd_digits(input int w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_add3_step.sv
// Double-dabble correction step: every BCD nibble >= 5 gets +3 so the
// following left shift carries correctly into the next decimal digit.
//   din  : N-digit packed BCD vector
//   dout : corrected vector, same layout
module bcd_add3_step #(
    parameter int N = 4
) (
    input  logic [4*N-1:0] din,
    output logic [4*N-1:0] dout
);

    for (genvar i = 0; i < N; i++) begin : g_nib
        assign dout[4*i +: 4] = (din[4*i +: 4] >= 4'd5) ? din[4*i +: 4] + 4'd3
                                                         : din[4*i +: 4];
    end

endmodule

// File: rtl/bin2ascii_seq.sv
// Sequential binary to ASCII decimal formatter (one bit per cycle).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_num is the value to convert
//   out_valid/out_ready  : output handshake
//   out_char             : {sign, digit[DIGITS-1] .. digit[0]}, one byte each
//   overflow             : magnitude does not fit in DIGITS decimal digits
module bin2ascii_seq
    import num_fmt_pkg::*;
#(
    parameter int         BIN_W    = 10,
    parameter int         DIGITS   = 4,
    parameter int         SIGNED   = 0,
    parameter int         BLANK_LZ = 1,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_num,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*(DIGITS+1)-1:0] out_char,
    output logic                    overflow
);

    localparam int NBCD = bcd_digits(BIN_W);
    localparam int MAXD = (DIGITS > NBCD) ? DIGITS : NBCD;
    localparam int CW   = $clog2(BIN_W + 1);

    fmt_state_e              state, state_nxt;
    logic [BIN_W:0]          shreg;
    logic [4*NBCD-1:0]       bcd, bcd_adj;
    logic                    neg;
    logic [CW-1:0]           cnt;

    logic                    neg_in;
    logic [BIN_W:0]          mag_in;
    logic [4*MAXD-1:0]       bcd_ext;
    logic [8*(DIGITS+1)-1:0] fmt_char;
    logic                    fmt_ovf;

    // Negation in BIN_W+1 bits so the most-negative input yields its true
    // magnitude (e.g. -512 -> 512) instead of wrapping.
    assign neg_in = (SIGNED != 0) && in_num[BIN_W-1];
    assign mag_in = neg_in ? (BIN_W+1)'(0) - {1'b1, in_num} : {1'b0, in_num};

    bcd_add3_step #(.N(NBCD)) u_add3 (
        .din  (bcd),
        .dout (bcd_adj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bcd      <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            out_char <= {PAD_CHAR, {DIGITS{ASCII_0}}};
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    shreg <= mag_in;
                    neg   <= neg_in;
                    bcd   <= '0;
                    cnt   <= '0;
                end
                SHIFT: begin
                    // Magnitude never exceeds 2**BIN_W-1, so the top shreg
                    // bit is always zero and the next bit enters at BIN_W-1.
                    bcd   <= (bcd_adj << 1) | {{(4*NBCD-1){1'b0}}, shreg[BIN_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt + CW'(1);
                end
                FORMAT: begin
                    out_char <= fmt_char;
                    overflow <= fmt_ovf;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT:  if (cnt == CW'(BIN_W - 1)) state_nxt = FORMAT;
            FORMAT: state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Character formatting. Digits above NBCD read as zero through bcd_ext.
    always_comb begin
        logic       lead;
        logic [3:0] nib;
        bcd_ext = '0;
        bcd_ext[4*NBCD-1:0] = bcd;
        fmt_ovf = 1'b0;
        for (int d = DIGITS; d < MAXD; d++)
            if (bcd_ext[4*d +: 4] != 4'd0) fmt_ovf = 1'b1;

        fmt_char = '0;
        fmt_char[8*DIGITS +: 8] = neg ? ASCII_MINUS : PAD_CHAR;
        lead = (BLANK_LZ != 0);
        nib  = '0;
        // Walk from the most significant digit; blanking stops at the first
        // nonzero digit and never reaches digit 0.
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = bcd_ext[4*d +: 4];
            if (nib != 4'd0 || d == 0) lead = 1'b0;
            if (fmt_ovf)   fmt_char[8*d +: 8] = ASCII_MINUS;
            else if (lead) fmt_char[8*d +: 8] = PAD_CHAR;
            else           fmt_char[8*d +: 8] = ASCII_0 + {4'd0, nib};
        end
    end

endmodule

// File: tb/tb_bin2ascii_seq.sv
// Bench for bin2ascii_seq: four parameterisations driven from one input
// stream (default, no blanking, signed, three digits).
module tb_bin2ascii_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [9:0]  in_num = '0;

    logic        rdy_def, rdy_nlz, rdy_sgn, rdy_d3;
    logic        vld_def, vld_nlz, vld_sgn, vld_d3;
    logic        ovf_def, ovf_nlz, ovf_sgn, ovf_d3;
    logic [39:0] ch_def, ch_nlz, ch_sgn;
    logic [31:0] ch_d3;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2ascii_seq u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_def), .in_num(in_num),
        .out_valid(vld_def), .out_ready(out_ready), .out_char(ch_def), .overflow(ovf_def));
    bin2ascii_seq #(.BLANK_LZ(0)) u_nlz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_nlz), .in_num(in_num),
        .out_valid(vld_nlz), .out_ready(out_ready), .out_char(ch_nlz), .overflow(ovf_nlz));
    bin2ascii_seq #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_sgn), .in_num(in_num),
        .out_valid(vld_sgn), .out_ready(out_ready), .out_char(ch_sgn), .overflow(ovf_sgn));
    bin2ascii_seq #(.DIGITS(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d3), .in_num(in_num),
        .out_valid(vld_d3), .out_ready(out_ready), .out_char(ch_d3), .overflow(ovf_d3));

    typedef struct {
        logic [9:0]  num;
        logic [39:0] def;
        logic [39:0] nlz;
        logic [39:0] sgn;
        logic [31:0] d3;
        logic        d3_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accepts num, then waits for out_valid. lat counts the accept cycle as
    // cycle 1, so out_valid should first be seen in cycle BIN_W+2 = 12.
    task automatic conv(input logic [9:0] num, output int lat, output int acc_cyc);
        lat = -1;
        for (int i = 0; i < 20 && !rdy_def; i++) step();
        in_valid = 1'b1;
        in_num   = num;
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (vld_def) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_valid_timeout: got no out_valid for input %0d", num);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, acc, acc_prev;
        bit seen;
        logic [39:0] exp_s[3];
        logic [9:0]  nums[3];

        vecs[0] = '{10'd987,  "  987", " 0987", "-  37", " 987", 1'b0};
        vecs[1] = '{10'd0,    "    0", " 0000", "    0", "   0", 1'b0};
        vecs[2] = '{10'd1023, " 1023", " 1023", "-   1", " ---", 1'b1};
        vecs[3] = '{10'h200,  "  512", " 0512", "- 512", " 512", 1'b0};
        vecs[4] = '{10'd511,  "  511", " 0511", "  511", " 511", 1'b0};
        vecs[5] = '{10'd1000, " 1000", " 1000", "-  24", " ---", 1'b1};
        vecs[6] = '{10'd999,  "  999", " 0999", "-  25", " 999", 1'b0};
        vecs[7] = '{10'd10,   "   10", " 0010", "   10", "  10", 1'b0};
        vecs[8] = '{10'd1,    "    1", " 0001", "    1", "   1", 1'b0};

        // reset state
        #12;
        chk("rst_out_valid", {63'd0, vld_def}, 64'd0);
        chk("rst_in_ready",  {63'd0, rdy_def}, 64'd1);
        chk("rst_overflow",  {63'd0, ovf_def}, 64'd0);
        chk("rst_char_def",  {24'd0, ch_def}, {24'd0, " 0000"});
        chk("rst_char_d3",   {32'd0, ch_d3},  {32'd0, " 000"});
        rst_n = 1'b1;
        step();

        // reset in the middle of SHIFT
        in_valid = 1'b1;
        in_num   = 10'd123;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  {63'd0, rdy_def}, 64'd1);
        chk("midrst_out_valid", {63'd0, vld_def}, 64'd0);
        chk("midrst_char",      {24'd0, ch_def}, {24'd0, " 0000"});
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (vld_def || !rdy_def) seen = 1'b1;
        end
        chk("midrst_no_partial", {63'd0, seen}, 64'd0);

        // table-driven conversions
        foreach (vecs[k]) begin
            conv(vecs[k].num, lat, acc);
            chk($sformatf("latency_%0d", vecs[k].num), 64'(lat), 64'd12);
            chk($sformatf("def_%0d", vecs[k].num), {24'd0, ch_def}, {24'd0, vecs[k].def});
            chk($sformatf("def_ovf_%0d", vecs[k].num), {63'd0, ovf_def}, 64'd0);
            chk($sformatf("nlz_%0d", vecs[k].num), {24'd0, ch_nlz}, {24'd0, vecs[k].nlz});
            chk($sformatf("sgn_%0d", vecs[k].num), {24'd0, ch_sgn}, {24'd0, vecs[k].sgn});
            chk($sformatf("d3_%0d", vecs[k].num), {32'd0, ch_d3}, {32'd0, vecs[k].d3});
            chk($sformatf("d3_ovf_%0d", vecs[k].num), {63'd0, ovf_d3}, {63'd0, vecs[k].d3_ovf});
            handshake();
        end

        // backpressure: result held for 5 cycles, concurrent input ignored
        conv(10'd42, lat, acc);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_num   = 10'd7;
            step();
            chk("bp_char",      {24'd0, ch_def}, {24'd0, "   42"});
            chk("bp_in_ready",  {63'd0, rdy_def}, 64'd0);
            chk("bp_out_valid", {63'd0, vld_def}, 64'd1);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_after_in_ready",  {63'd0, rdy_def}, 64'd1);
        chk("bp_after_out_valid", {63'd0, vld_def}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (vld_def) seen = 1'b1;
        end
        chk("bp_no_queued_input", {63'd0, seen}, 64'd0);
        chk("bp_char_kept",       {24'd0, ch_def}, {24'd0, "   42"});

        // back-to-back stream, handshake as soon as out_valid appears
        nums[0] = 10'd5;   exp_s[0] = "    5";
        nums[1] = 10'd50;  exp_s[1] = "   50";
        nums[2] = 10'd500; exp_s[2] = "  500";
        acc_prev = 0;
        for (int k = 0; k < 3; k++) begin
            conv(nums[k], lat, acc);
            chk($sformatf("stream_char_%0d", k), {24'd0, ch_def}, {24'd0, exp_s[k]});
            if (k > 0) chk($sformatf("stream_period_%0d", k), 64'(acc - acc_prev), 64'd13);
            acc_prev = acc;
            handshake();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
